regfile_2r1w_sb: RTL and testbench
==================================

// Module: regfile_2r1w_sb
// PURPOSE
//  Parametrised 2-read/1-write register file with a per-register busy scoreboard; successor to the 8x16 1R1W regfile.
//  Sits between decode (2 source reads + destination reservation) and writeback (1 write) in the datapath.
//  Busy bits let the controller stall on read-after-write hazards; sync reset clears data and scoreboard.
// PARAMETERS
//  WIDTH  16  data bits per register
//  DEPTH  8   number of registers (power of 2, >=2)
//  AW     $clog2(DEPTH)  address width (derived, do not override)
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous, active-high reset
//  w_en      in   1      write enable (writeback)
//  w_addr    in   AW     write address
//  w_data    in   WIDTH  write data
//  r_addr_a  in   AW     read port A address
//  r_data_a  out  WIDTH  read port A data (combinational)
//  busy_a    out  1      busy[r_addr_a] (combinational)
//  r_addr_b  in   AW     read port B address
//  r_data_b  out  WIDTH  read port B data (combinational)
//  busy_b    out  1      busy[r_addr_b] (combinational)
//  rsv_en    in   1      request: mark rsv_addr busy (pending writeback)
//  rsv_addr  in   AW     register to reserve
//  rsv_stall out  1      reservation refused this cycle (combinational)
//  busy_vec  out  DEPTH  registered scoreboard, bit i = register i busy
// BEHAVIOUR
//  - One clock, clk; reset rst is synchronous, active-high. At the rst edge: all registers = 0; busy_vec = 0. rst overrides w_en/rsv_en.
//  - Write: at posedge, if w_en & ~rst, reg[w_addr] <= w_data and busy[w_addr] <= 0. No w_en -> no register changes.
//  - Reads: r_data_x = reg[r_addr_x]; new data is visible the cycle after the write edge (latency 1). Both ports may read the same address.
//  - rsv_stall = rsv_en & busy[rsv_addr] & ~(w_en & w_addr==rsv_addr).
//  - Reserve: at posedge, if rsv_en & ~rsv_stall, busy[rsv_addr] <= 1. A stalled request changes no state.
//  - Simultaneous w_en and rsv_en to the same address: data is written; busy ends at 1 (reserve wins); rsv_stall = 0.
//  - Simultaneous w_en and rsv_en to different addresses: both take effect independently.
//  - Writing a non-busy register is legal (busy stays 0).
//  - busy_a/busy_b reflect registered busy_vec and are not bypassed by the same-cycle w_en.
//  - Addresses are always in range (DEPTH is a power of 2); no wrap logic is needed.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - If w_en & w_addr==r_addr_x, r_data_x = w_data in the same cycle (write-through).
//    - busy_x is forced to 0 in that case.
//  REGFILE_BYPASS_EN undefined:
//    - Reads return the stored (old) value until the write edge; busy_x is unaffected.
// STRUCTURE
//  - Package regfile_pkg: REGFILE_WIDTH=16, REGFILE_DEPTH=8 constants; typedefs reg_t (logic [WIDTH-1:0]), addr_t (logic [AW-1:0]).
//  - Sub-module regfile_read_port: read mux plus optional bypass/busy override, instantiated twice (ports A, B).
//  - Top level holds the storage array, the busy_vec register and the rsv_stall logic.
// TESTING
//  1. rst=1 for 1 cycle, then read r0..r7 on both ports -> all 0; busy_vec=8'h00.
//  2. w_en=0, w_data=16'd6009, w_addr=0, 1 clk -> r_data_a(r_addr_a=0) stays 0.
//  3. w_en=1 for each i=0..7: write i*1010+909, 1 clk -> next cycle r_data_a and r_data_b at i read i*1010+909.
//  4. rsv_en=1, rsv_addr=3 -> busy_vec=8'h08, busy_a=1 at r_addr_a=3; repeat rsv 3 -> rsv_stall=1, state unchanged.
//     Then w_en to r3 = 16'd3939 -> busy_vec=0, r_data=3939.
//  5. Same cycle: w_en to r5 = 16'd5959 and rsv_en to r5 -> rsv_stall=0; next cycle r5=5959, busy_vec[5]=1.
//  6. w_en to r2 = 16'h2929 with r_addr_a=2 -> same cycle r_data_a=2929 iff REGFILE_BYPASS_EN, else old value.
//     Then assert rst mid-sequence -> all data and busy cleared at that edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the 2R1W register file with busy scoreboard.
package regfile_pkg;

  localparam int REGFILE_WIDTH = 16;
  localparam int REGFILE_DEPTH = 8;
  localparam int REGFILE_AW    = $clog2(REGFILE_DEPTH);

  typedef logic [REGFILE_WIDTH-1:0] reg_t;
  typedef logic [REGFILE_AW-1:0]    addr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port: storage mux plus busy lookup; write-through bypass when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter  int WIDTH = REGFILE_WIDTH,
  parameter  int DEPTH = REGFILE_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
  input  logic [DEPTH-1:0]            busy_vec,
  input  logic [AW-1:0]               r_addr,
  input  logic                        w_en,
  input  logic [AW-1:0]               w_addr,
  input  logic [WIDTH-1:0]            w_data,
  output logic [WIDTH-1:0]            r_data,
  output logic                        busy
);

  always_comb begin
    r_data = mem[r_addr];
    busy   = busy_vec[r_addr];
`ifdef REGFILE_BYPASS_EN
    // Write-through: the value landing this cycle is already final, so it is not busy.
    if (w_en && (w_addr == r_addr)) begin
      r_data = w_data;
      busy   = 1'b0;
    end
`endif
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{w_en, w_addr, w_data};
`endif

endmodule

// File: rtl/regfile_2r1w_sb.sv
// 2-read/1-write register file with per-register busy scoreboard for RAW hazard stalls.
// Optional same-cycle write-through on reads: define REGFILE_BYPASS_EN.
module regfile_2r1w_sb
  import regfile_pkg::*;
#(
  parameter  int WIDTH = REGFILE_WIDTH,
  parameter  int DEPTH = REGFILE_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  input  logic [AW-1:0]    r_addr_a,
  output logic [WIDTH-1:0] r_data_a,
  output logic             busy_a,
  input  logic [AW-1:0]    r_addr_b,
  output logic [WIDTH-1:0] r_data_b,
  output logic             busy_b,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_stall,
  output logic [DEPTH-1:0] busy_vec
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]            busy_nxt;

  // A write retiring the same register frees it this cycle, so the reservation may proceed.
  assign rsv_stall = rsv_en && busy_vec[rsv_addr] && !(w_en && (w_addr == rsv_addr));

  always_comb begin
    busy_nxt = busy_vec;
    if (w_en) busy_nxt[w_addr] = 1'b0;
    // Applied after the write clear so a same-address reservation wins.
    if (rsv_en && !rsv_stall) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem      <= '0;
      busy_vec <= '0;
    end else begin
      if (w_en) mem[w_addr] <= w_data;
      busy_vec <= busy_nxt;
    end
  end

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_a (
    .mem      (mem),
    .busy_vec (busy_vec),
    .r_addr   (r_addr_a),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_data   (r_data_a),
    .busy     (busy_a)
  );

  regfile_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_port_b (
    .mem      (mem),
    .busy_vec (busy_vec),
    .r_addr   (r_addr_b),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .r_data   (r_data_b),
    .busy     (busy_b)
  );

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: hand-computed vector table, directed corner sequences, randomized run vs. reference model.
module tb_regfile_2r1w_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, w_en, rsv_en;
  logic [2:0]  w_addr, r_addr_a, r_addr_b, rsv_addr;
  logic [15:0] w_data;
  logic [15:0] r_data_a, r_data_b;
  logic        busy_a, busy_b, rsv_stall;
  logic [7:0]  busy_vec;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_m [8];
  logic [7:0]  busy_m;

  always #5 clk = ~clk;

  regfile_2r1w_sb dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_addr_a(r_addr_a), .r_data_a(r_data_a), .busy_a(busy_a),
    .r_addr_b(r_addr_b), .r_data_b(r_data_b), .busy_b(busy_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_stall(rsv_stall), .busy_vec(busy_vec)
  );

  typedef struct {
    logic        w_en;
    logic [2:0]  w_addr;
    logic [15:0] w_data;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_busy_a;
    logic        exp_stall;
    logic [7:0]  exp_vec;
  } vec_t;

  vec_t tbl[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference model: register array plus busy flags, updated by the behavioural rules.
  function automatic logic [15:0] m_rd(logic [2:0] a);
    if (BYP && w_en && w_addr == a) return w_data;
    return mem_m[a];
  endfunction

  function automatic logic m_busy(logic [2:0] a);
    if (BYP && w_en && w_addr == a) return 1'b0;
    return busy_m[a];
  endfunction

  function automatic logic m_stall();
    return rsv_en && busy_m[rsv_addr] && !(w_en && w_addr == rsv_addr);
  endfunction

  function automatic void m_edge();
    logic st;
    st = m_stall();
    if (rst) begin
      for (int i = 0; i < 8; i++) mem_m[i] = 16'h0;
      busy_m = 8'h00;
    end else begin
      if (w_en) begin
        mem_m[w_addr]  = w_data;
        busy_m[w_addr] = 1'b0;
      end
      if (rsv_en && !st) busy_m[rsv_addr] = 1'b1;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; w_en = 1'b0; w_addr = '0; w_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; r_addr_a = '0; r_addr_b = '0;
  endtask

  function automatic vec_t mk(logic we, logic [2:0] wa, logic [15:0] wd, logic re, logic [2:0] rsa,
                              logic [2:0] ra, logic [2:0] rb, logic [15:0] ea, logic [15:0] eb,
                              logic eba, logic est, logic [7:0] ev);
    vec_t v;
    v.w_en = we; v.w_addr = wa; v.w_data = wd; v.rsv_en = re; v.rsv_addr = rsa;
    v.ra = ra; v.rb = rb; v.exp_a = ea; v.exp_b = eb; v.exp_busy_a = eba;
    v.exp_stall = est; v.exp_vec = ev;
    return v;
  endfunction

  initial begin
    idle();
    for (int i = 0; i < 8; i++) mem_m[i] = 16'h0;
    busy_m = 8'h00;

    // Table rows: this cycle's outputs, then busy_vec after the edge. No row depends on bypass.
    tbl.push_back(mk(0, 0, 16'd6009, 0, 0, 0, 0, 16'd0, 16'd0, 0, 0, 8'h00));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 3'(i), 16'(i * 1010 + 909), 0, 0, 3'((i + 7) % 8), 3'((i + 7) % 8),
                       (i == 0) ? 16'd0 : 16'((i - 1) * 1010 + 909),
                       (i == 0) ? 16'd0 : 16'((i - 1) * 1010 + 909), 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7, 0, 16'd7979, 16'd909, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 1, 3, 3, 0, 16'd3939, 16'd909, 0, 0, 8'h08));
    tbl.push_back(mk(0, 0, 0, 1, 3, 3, 1, 16'd3939, 16'd1919, 1, 1, 8'h08));
    tbl.push_back(mk(1, 3, 16'd3939, 0, 0, 4, 3, 16'd4949, 16'd3939, 0, 0, 8'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 2, 16'd3939, 16'd2929, 0, 0, 8'h00));
    tbl.push_back(mk(1, 5, 16'd5959, 1, 5, 0, 1, 16'd909, 16'd1919, 0, 0, 8'h20));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 5, 16'd5959, 16'd5959, 1, 0, 8'h20));
    tbl.push_back(mk(1, 5, 16'd1234, 1, 6, 6, 7, 16'd6969, 16'd7979, 0, 0, 8'h40));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 6, 16'd1234, 16'd6969, 0, 0, 8'h40));

    // Reset, then every register reads zero on both ports.
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_busy_vec", busy_vec, 8'h00);
    for (int i = 0; i < 8; i++) begin
      r_addr_a = 3'(i); r_addr_b = 3'(7 - i);
      #1;
      chk($sformatf("reset_rd_a[%0d]", i), r_data_a, 16'h0);
      chk($sformatf("reset_rd_b[%0d]", 7 - i), r_data_b, 16'h0);
    end

    foreach (tbl[k]) begin
      w_en = tbl[k].w_en; w_addr = tbl[k].w_addr; w_data = tbl[k].w_data;
      rsv_en = tbl[k].rsv_en; rsv_addr = tbl[k].rsv_addr;
      r_addr_a = tbl[k].ra; r_addr_b = tbl[k].rb;
      #3;
      chk($sformatf("tbl%0d_rd_a", k), r_data_a, tbl[k].exp_a);
      chk($sformatf("tbl%0d_rd_b", k), r_data_b, tbl[k].exp_b);
      chk($sformatf("tbl%0d_busy_a", k), busy_a, tbl[k].exp_busy_a);
      chk($sformatf("tbl%0d_stall", k), rsv_stall, tbl[k].exp_stall);
      step();
      chk($sformatf("tbl%0d_busy_vec", k), busy_vec, tbl[k].exp_vec);
    end
    idle();

    // Bypass corner: reserve r2, then write it while reading it in the same cycle.
    rsv_en = 1'b1; rsv_addr = 3'd2;
    step();
    idle();
    chk("byp_busy_vec_rsv", busy_vec, 8'h44);
    w_en = 1'b1; w_addr = 3'd2; w_data = 16'h2929; r_addr_a = 3'd2;
    #3;
    chk("byp_rd_a_same_cycle", r_data_a, BYP ? 16'h2929 : 16'd2929);
    chk("byp_busy_a_same_cycle", busy_a, BYP ? 1'b0 : 1'b1);
    step();
    w_en = 1'b0;
    #1;
    chk("byp_rd_a_after", r_data_a, 16'h2929);
    chk("byp_busy_vec_after", busy_vec, 8'h40);

    // Reset asserted mid-sequence overrides concurrent write and reservation.
    rsv_en = 1'b1; rsv_addr = 3'd1;
    step();
    chk("pre_rst_busy_vec", busy_vec, 8'h42);
    rst = 1'b1; w_en = 1'b1; w_addr = 3'd4; w_data = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd0;
    step();
    idle();
    #1;
    chk("mid_rst_busy_vec", busy_vec, 8'h00);
    for (int i = 0; i < 8; i++) begin
      r_addr_a = 3'(i);
      #1;
      chk($sformatf("mid_rst_rd[%0d]", i), r_data_a, 16'h0);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      w_en     = ($urandom_range(0, 2) != 0);
      w_addr   = 3'($urandom_range(0, 7));
      w_data   = 16'($urandom);
      rsv_en   = ($urandom_range(0, 1) != 0);
      rsv_addr = 3'($urandom_range(0, 7));
      r_addr_a = 3'($urandom_range(0, 7));
      r_addr_b = ($urandom_range(0, 3) == 0) ? r_addr_a : 3'($urandom_range(0, 7));
      #3;
      chk("rnd_rd_a", r_data_a, m_rd(r_addr_a));
      chk("rnd_rd_b", r_data_b, m_rd(r_addr_b));
      chk("rnd_busy_a", busy_a, m_busy(r_addr_a));
      chk("rnd_busy_b", busy_b, m_busy(r_addr_b));
      chk("rnd_stall", rsv_stall, m_stall());
      chk("rnd_busy_vec", busy_vec, busy_m);
      step();
    end
    idle();
    #1;
    chk("final_busy_vec", busy_vec, busy_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
